// File: rtl/pedestrian_signal_controller.sv
// pedestrian_signal_controller
// Latches pedestrian button requests and drives the WALK / DONT_WALK lamp pair
// (steady WALK, flashing DONT_WALK, steady DONT_WALK) inside a vehicle red phase.
// Any loss of red aborts to DONT_WALK. A non-one-hot light code locks the
// block in FAULT until reset.
// Build option: define PED_COUNTDOWN_EN to drive the countdown port from the
// phase counter. When it is undefined, countdown is tied to 0.
module pedestrian_signal_controller #(
    parameter int WALK_CYCLES  = 6,
    parameter int FLASH_CYCLES = 4,
    parameter int BLINK_DIV    = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             RED,
    input  logic             GREEN,
    input  logic             YELLOW,
    input  logic             ped_button,
    output logic             WALK,
    output logic             DONT_WALK,
    output logic             ped_waiting,
    output logic [CNT_W-1:0] countdown,
    output logic             fault
);

    typedef enum logic [2:0] {S_IDLE, S_WALK, S_FLASH, S_DONE, S_FAULT} state_t;

    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               r_req, w_req_n;
    logic [BLK_W-1:0]   r_blk_cnt, w_blk_cnt_n;
    logic               r_blk_ph, w_blk_ph_n;
    logic               r_red_q, r_btn_q;
    logic               w_red_rise, w_btn_rise;
    logic [2:0]         w_code;
    logic               w_onehot;

    assign w_red_rise = RED & ~r_red_q;
    assign w_btn_rise = ped_button & ~r_btn_q;
    assign w_code     = {RED, GREEN, YELLOW};
    assign w_onehot   = (w_code == 3'b100) || (w_code == 3'b010) || (w_code == 3'b001);

    // Edge-detect history. red_q resets high so a red phase already running at reset is not a rise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_red_q <= 1'b1;
            r_btn_q <= 1'b0;
        end else begin
            r_red_q <= RED;
            r_btn_q <= ped_button;
        end
    end

    // State, phase counter, request latch and blink generator registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_blk_cnt <= '0;
            r_blk_ph  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_req     <= w_req_n;
            r_blk_cnt <= w_blk_cnt_n;
            r_blk_ph  <= w_blk_ph_n;
        end
    end

    // Next-state logic. Priority: illegal light code, then loss of red, then normal sequencing.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_req_n     = r_req;
        w_blk_cnt_n = r_blk_cnt;
        w_blk_ph_n  = r_blk_ph;
        if (!w_onehot) begin
            w_state_n = S_FAULT;
            w_cnt_n   = '0;
            w_req_n   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_red_rise && (r_req || w_btn_rise)) begin
                        w_state_n = S_WALK;
                        w_cnt_n   = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
                        w_req_n   = 1'b0;
                    end else if (w_btn_rise) begin
                        w_req_n = 1'b1;
                    end
                end
                S_WALK: begin
                    if (!RED) begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(FLASH_CYCLES)) begin
                            w_state_n   = S_FLASH;
                            w_blk_cnt_n = '0;
                            w_blk_ph_n  = 1'b0;
                        end
                    end
                end
                S_FLASH: begin
                    if (!RED) begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        if (r_cnt == '0) begin
                            w_state_n = S_DONE;
                        end else begin
                            w_cnt_n = r_cnt - 1'b1;
                        end
                        if (r_blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
                            w_blk_cnt_n = '0;
                            w_blk_ph_n  = ~r_blk_ph;
                        end else begin
                            w_blk_cnt_n = r_blk_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_cnt_n = '0;
                    if (w_btn_rise) w_req_n = 1'b1;
                    if (!RED) w_state_n = S_IDLE;
                end
                S_FAULT: begin
                    w_cnt_n = '0;
                    w_req_n = 1'b0;
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    // Lamps are decoded from registered state only; the two lamps are mutually exclusive by construction.
    assign WALK        = (r_state == S_WALK);
    assign DONT_WALK   = (r_state != S_WALK) && !((r_state == S_FLASH) && r_blk_ph);
    assign ped_waiting = r_req;
    assign fault       = (r_state == S_FAULT);

`ifdef PED_COUNTDOWN_EN
    assign countdown = r_cnt;
`else
    assign countdown = '0;
`endif

endmodule
